// File: rtl/key_entry.sv
// Keypad key-code consumer: assembles digit keys into a BCD entry buffer with
// backspace/clear/enter editing. Optional idle timeout: define KEY_ENTRY_TIMEOUT_EN.
module key_entry #(
   parameter int unsigned DIGITS      = 4,
   parameter int unsigned TIMEOUT_CYC = 250_000_000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  key_vld,
   input  logic [3:0]            key_out,
   output logic [4*DIGITS-1:0]   entry_bcd,
   output logic [2:0]            entry_cnt,
   output logic [4*DIGITS-1:0]   entry_val,
   output logic                  entry_done,
   output logic                  err,
   output logic                  timeout
);

   localparam int unsigned W       = 4 * DIGITS;
   localparam logic [2:0]  CNT_MAX = 3'(DIGITS);

   if (DIGITS < 1 || DIGITS > 7 || TIMEOUT_CYC < 1) begin : g_bad_param
      $error("key_entry: DIGITS must be 1..7 and TIMEOUT_CYC at least 1");
   end

   typedef enum logic [1:0] {EMPTY, ENTRY, FULL} state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  bcd_d, val_d;
   logic [2:0]    cnt_d;
   logic          done_d, err_d;
   logic [W+3:0]  shl;
   logic          idle_hit;

   // Shift-in built one nibble wide so the slice stays legal when DIGITS=1.
   assign shl = {entry_bcd, key_out};

`ifdef KEY_ENTRY_TIMEOUT_EN
   localparam logic [27:0] IDLE_LAST = 28'(TIMEOUT_CYC - 1);
   logic [27:0] idle_q;
   logic        timeout_q;

   assign idle_hit = (state_q != EMPTY) && !key_vld && (idle_q == IDLE_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idle_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= idle_hit;
         if (key_vld || state_q == EMPTY || idle_hit)
            idle_q <= '0;
         else
            idle_q <= idle_q + 28'd1;
      end
   end

   assign timeout = timeout_q;
`else
   assign idle_hit = 1'b0;
   assign timeout  = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      bcd_d   = entry_bcd;
      cnt_d   = entry_cnt;
      val_d   = entry_val;
      done_d  = 1'b0;
      err_d   = 1'b0;
      if (key_vld) begin
         if (key_out <= 4'h9) begin
            if (state_q == FULL) begin
               err_d = 1'b1;
            end else begin
               bcd_d   = shl[W-1:0];
               cnt_d   = entry_cnt + 3'd1;
               state_d = (cnt_d == CNT_MAX) ? FULL : ENTRY;
            end
         end else begin
            case (key_out)
               4'hA: begin
                  if (state_q != EMPTY) begin
                     bcd_d   = entry_bcd >> 4;
                     cnt_d   = entry_cnt - 3'd1;
                     state_d = (cnt_d == 3'd0) ? EMPTY : ENTRY;
                  end
               end
               4'hB: begin
                  bcd_d   = '0;
                  cnt_d   = '0;
                  state_d = EMPTY;
               end
               4'hC: begin
                  if (state_q == EMPTY) begin
                     err_d = 1'b1;
                  end else begin
                     val_d   = entry_bcd;
                     done_d  = 1'b1;
                     bcd_d   = '0;
                     cnt_d   = '0;
                     state_d = EMPTY;
                  end
               end
               default: ;
            endcase
         end
      end else if (idle_hit) begin
         bcd_d   = '0;
         cnt_d   = '0;
         state_d = EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= EMPTY;
         entry_bcd  <= '0;
         entry_cnt  <= '0;
         entry_val  <= '0;
         entry_done <= 1'b0;
         err        <= 1'b0;
      end else begin
         state_q    <= state_d;
         entry_bcd  <= bcd_d;
         entry_cnt  <= cnt_d;
         entry_val  <= val_d;
         entry_done <= done_d;
         err        <= err_d;
      end
   end

endmodule
